frame_sdram_writer: RTL
=======================

FRAME_SDRAM_WRITER -- requirements
Module: frame_sdram_writer

Interface
REQ-001 SHALL have parameter DATA_W, default 64, Avalon data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 32, Avalon byte address width.
REQ-003 SHALL have parameter BURST_LEN, default 16, maximum beats per burst (power of two, 2..64).
REQ-004 SHALL have parameter FIFO_DEPTH, default 32, input buffer words (power of two, >= 2*BURST_LEN).
REQ-005 SHALL have ports, clock and reset first: clk100 in 1, sole clock; reset in 1, asynchronous active-high reset.
REQ-006 SHALL have ports: start in 1, arm one frame; frame_words in 24, words per frame (>0); base_addr0 in ADDR_W, frame buffer 0 byte address; base_addr1 in ADDR_W, frame buffer 1 byte address.
REQ-007 SHALL have ports: in_valid in 1, in_data in DATA_W, in_ready out 1 (pixel-word stream).
REQ-008 SHALL have ports: address out ADDR_W; burstcount out 7; write out 1; writedata out DATA_W; byteenable out DATA_W/8; waitrequest in 1 (f2h_sdram write master).
REQ-009 SHALL have ports: busy out 1, frame_done out 1 (one-cycle pulse), buf_sel out 1 (buffer of last/current frame).

Function
REQ-010 SHALL be an FSM with states IDLE, FILL, BURST, DONE.
REQ-011 IDLE: start=1 latches frame_words, clears word/address counters, selects base address, goes to FILL; busy=1 from the next cycle.
REQ-012 in_ready SHALL be 1 only when state != IDLE/DONE, FIFO not full and accepted-word count < frame_words; a word is accepted when in_valid && in_ready.
REQ-013 FILL->BURST when FIFO count >= min(BURST_LEN, frame_words - words_written); burstcount latched to that value on entry.
REQ-014 BURST: write=1, address and burstcount constant for all beats of the burst; writedata = FIFO head; a beat completes on write && !waitrequest, popping the FIFO.
REQ-015 While waitrequest=1, write, address, burstcount, writedata SHALL hold unchanged.
REQ-016 byteenable SHALL be all ones whenever write=1, zero otherwise.
REQ-017 After the last beat of a burst, address SHALL advance by burstcount*DATA_W/8; next state is FILL, or DONE if words_written == frame_words.
REQ-018 DONE: frame_done=1 for exactly one cycle, busy=0, return to IDLE; write=0 in DONE and IDLE.
REQ-019 A final burst SHALL be short (burstcount < BURST_LEN) when frame_words is not a multiple of BURST_LEN.
REQ-020 start while busy SHALL be ignored.
REQ-021 Simultaneous push and pop SHALL leave FIFO count unchanged; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-022 Latency: first beat no earlier than 2 cycles after the word completing the burst threshold is accepted.

Reset
REQ-023 reset SHALL force IDLE, FIFO empty, all counters 0, write/busy/frame_done/in_ready/buf_sel/burstcount/address/byteenable = 0, asynchronously, including mid-burst; next frame needs a new start.

Configuration
REQ-024 With FRAME_WRITER_DOUBLE_BUF_EN defined: each accepted start toggles buf_sel (first frame after reset uses buffer 0) and base_addr selected by buf_sel.
REQ-025 Without FRAME_WRITER_DOUBLE_BUF_EN: base_addr0 always used, buf_sel constant 0, base_addr1 unused.

Structure
REQ-026 Package hdr_wr_pkg SHALL hold the state enum type and the burstcount width constant.
REQ-027 Input buffer SHALL be sub-module wr_burst_fifo (synchronous FIFO, count output); FSM and address generation in frame_sdram_writer.

Verification
REQ-028 frame_words=32, BURST_LEN=16, base_addr0=0x1000_0000, no waitrequest -> two bursts at 0x1000_0000 and 0x1000_0080, burstcount 16, frame_done once.
REQ-029 frame_words=20 -> bursts of 16 then 4 at +0x80; 20 beats total, data in input order.
REQ-030 waitrequest high 3 cycles on beat 5 -> write/address/writedata stable those cycles; no beat lost or duplicated.
REQ-031 in_valid continuously 1 with waitrequest stuck high -> in_ready drops when FIFO holds 32 words; no overflow.
REQ-032 reset asserted mid-burst (beat 7) -> write=0, busy=0 immediately; new start writes full frame from base address.
REQ-033 DOUBLE_BUF_EN, base_addr1=0x2000_0000, three frames -> buffers 0,1,0; start during busy ignored.

Source files
------------

// File: rtl/hdr_wr_pkg.sv
// Package for the frame SDRAM writer slice.
// Holds the writer FSM state type and the shared width constants.
package hdr_wr_pkg;

    // Avalon burstcount port width (up to 64 beats).
    localparam int BC_W    = 7;
    // Width of the words-per-frame control input and the word counters.
    localparam int FRAME_W = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_BURST = 2'd2,
        ST_DONE  = 2'd3
    } wr_state_t;

endpackage

// File: rtl/frame_sdram_writer_if.sv
// Bus interface for frame_sdram_writer: the incoming pixel-word stream and
// the outgoing Avalon-MM (f2h_sdram) burst write master.
//   master : the writer's view (consumes the stream, drives the Avalon write)
//   slave  : the environment's view (source of words, SDRAM port)
//
// Handshakes:
//   stream : a word transfers on a clock edge where in_valid && in_ready.
//   avalon : a beat transfers on a clock edge where write && !waitrequest;
//            while waitrequest is high the master holds write, address,
//            burstcount and writedata unchanged.
interface frame_sdram_writer_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32
);
    logic                        in_valid;
    logic [DATA_W-1:0]           in_data;
    logic                        in_ready;
    logic [ADDR_W-1:0]           address;
    logic [hdr_wr_pkg::BC_W-1:0] burstcount;
    logic                        write;
    logic [DATA_W-1:0]           writedata;
    logic [DATA_W/8-1:0]         byteenable;
    logic                        waitrequest;

    modport master (
        input  in_valid, in_data, waitrequest,
        output in_ready, address, burstcount, write, writedata, byteenable
    );

    modport slave (
        output in_valid, in_data, waitrequest,
        input  in_ready, address, burstcount, write, writedata, byteenable
    );
endinterface

// File: rtl/wr_burst_fifo.sv
// Synchronous FIFO buffering incoming pixel words ahead of the SDRAM bursts.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (empties the FIFO)
//   push, push_data write side (ignored when full)
//   pop             read side (ignored when empty)
//   head            word at the read pointer (show-ahead)
//   count, full     occupancy; count is unchanged on simultaneous push+pop
// Pointers are $clog2(DEPTH) bits so they wrap modulo DEPTH (power of two).
module wr_burst_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    // Storage carries no reset; only the pointers and count define contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/frame_sdram_writer.sv
// Frame writer: buffers a pixel-word stream and writes one frame at a time
// into SDRAM through Avalon-MM bursts of up to BURST_LEN beats.
// Ports:
//   clk100, reset           sole clock, asynchronous active-high reset
//   start, frame_words      arm one frame of frame_words words (ignored if busy)
//   base_addr0, base_addr1  frame buffer byte addresses
//   bus (master modport)    in_valid/in_data/in_ready stream and the
//                           address/burstcount/write/writedata/byteenable/
//                           waitrequest Avalon write master
//   busy, frame_done        frame in progress, one-cycle end-of-frame pulse
//   buf_sel                 buffer used by the last/current frame
//   state_dbg               current FSM state
// Optional feature: define FRAME_WRITER_DOUBLE_BUF_EN to alternate frames
// between base_addr0 and base_addr1 (first frame after reset uses buffer 0).
module frame_sdram_writer
    import hdr_wr_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 32,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                clk100,
    input  logic                reset,
    input  logic                start,
    input  logic [FRAME_W-1:0]  frame_words,
    input  logic [ADDR_W-1:0]   base_addr0,
    input  logic [ADDR_W-1:0]   base_addr1,
    frame_sdram_writer_if.master bus,
    output logic                busy,
    output logic                frame_done,
    output logic                buf_sel,
    output wr_state_t           state_dbg
);
    localparam int BYTES = DATA_W / 8;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    wr_state_t          state;
    logic [FRAME_W-1:0] frame_len;
    logic [FRAME_W-1:0] acc_cnt;     // words accepted this frame
    logic [FRAME_W-1:0] wr_cnt;      // words written this frame
    logic [BC_W-1:0]    beat_cnt;
    logic [ADDR_W-1:0]  address_q;
    logic [BC_W-1:0]    burstcount_q;
    logic               write_q;

    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic [DATA_W-1:0]  fifo_head;
    logic               push;
    logic               pop;

    logic [FRAME_W-1:0] remaining;
    logic [BC_W-1:0]    need;
    logic               last_beat;
    logic [ADDR_W-1:0]  start_addr;

    assign bus.in_ready = ((state == ST_FILL) || (state == ST_BURST)) &&
                          !fifo_full && (acc_cnt < frame_len);
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = write_q && !bus.waitrequest;

    // Next burst length: a full burst, or whatever is left of the frame.
    assign remaining = frame_len - wr_cnt;
    assign need      = (remaining >= FRAME_W'(BURST_LEN)) ? BC_W'(BURST_LEN)
                                                          : remaining[BC_W-1:0];
    assign last_beat = (beat_cnt == burstcount_q - 1'b1);

    assign bus.address    = address_q;
    assign bus.burstcount = burstcount_q;
    assign bus.write      = write_q;
    assign bus.writedata  = fifo_head;
    assign bus.byteenable = write_q ? '1 : '0;
    assign state_dbg      = state;

`ifdef FRAME_WRITER_DOUBLE_BUF_EN
    logic used_once;   // a frame has been started since reset
    logic next_sel;

    assign next_sel   = used_once ? ~buf_sel : 1'b0;
    assign start_addr = next_sel ? base_addr1 : base_addr0;

    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            used_once <= 1'b0;
            buf_sel   <= 1'b0;
        end else if ((state == ST_IDLE) && start) begin
            used_once <= 1'b1;
            buf_sel   <= next_sel;
        end
    end
`else
    logic unused_base1;

    assign start_addr   = base_addr0;
    assign buf_sel      = 1'b0;
    assign unused_base1 = ^base_addr1;
`endif

    wr_burst_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk100),
        .rst       (reset),
        .push      (push),
        .push_data (bus.in_data),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full)
    );

    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            frame_len    <= '0;
            acc_cnt      <= '0;
            wr_cnt       <= '0;
            beat_cnt     <= '0;
            address_q    <= '0;
            burstcount_q <= '0;
            write_q      <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            if (push) acc_cnt <= acc_cnt + 1'b1;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        frame_len <= frame_words;
                        acc_cnt   <= '0;
                        wr_cnt    <= '0;
                        beat_cnt  <= '0;
                        address_q <= start_addr;
                        busy      <= 1'b1;
                        state     <= ST_FILL;
                    end
                end

                ST_FILL: begin
                    // Wait until the whole burst is buffered so the beats can
                    // stream back to back once write is raised.
                    if (FRAME_W'(fifo_count) >= FRAME_W'(need)) begin
                        burstcount_q <= need;
                        beat_cnt     <= '0;
                        write_q      <= 1'b1;
                        state        <= ST_BURST;
                    end
                end

                ST_BURST: begin
                    if (pop) begin
                        wr_cnt   <= wr_cnt + 1'b1;
                        beat_cnt <= beat_cnt + 1'b1;
                        if (last_beat) begin
                            write_q   <= 1'b0;
                            address_q <= address_q +
                                         ADDR_W'(burstcount_q) * ADDR_W'(BYTES);
                            if (wr_cnt + 1'b1 == frame_len) begin
                                busy       <= 1'b0;
                                frame_done <= 1'b1;
                                state      <= ST_DONE;
                            end else begin
                                state <= ST_FILL;
                            end
                        end
                    end
                end

                ST_DONE: begin
                    frame_done <= 1'b0;
                    state      <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
